// File: rtl/rtc_pkg.sv
// Shared constants for the RTC bus responder: register map, control bits, month lengths.
package rtc_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_SEC    = 8'h21;
    localparam logic [7:0] ADDR_MIN    = 8'h22;
    localparam logic [7:0] ADDR_HOUR   = 8'h23;
    localparam logic [7:0] ADDR_DAY    = 8'h24;
    localparam logic [7:0] ADDR_MONTH  = 8'h25;
    localparam logic [7:0] ADDR_YEAR   = 8'h26;
    localparam logic [7:0] ADDR_TSEC   = 8'h41;
    localparam logic [7:0] ADDR_TMIN   = 8'h42;
    localparam logic [7:0] ADDR_THOUR  = 8'h43;
    localparam logic [7:0] ADDR_STATUS = 8'h50;

    localparam int unsigned CTRL_12H_BIT     = 4;
    localparam int unsigned HOUR_PM_BIT      = 5;
    localparam int unsigned STATUS_ALARM_BIT = 0;

    // Last valid day (BCD) of each month, January first; February is the non-leap length.
    localparam logic [7:0] MONTH_LEN [12] = '{
        8'h31, 8'h28, 8'h31, 8'h30, 8'h31, 8'h30,
        8'h31, 8'h31, 8'h30, 8'h31, 8'h30, 8'h31
    };

    // Two-digit BCD to binary (digits above 9 are accepted and simply weighted).
    function automatic logic [7:0] bcd_to_bin(input logic [7:0] v);
        return 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
    endfunction

    // Last day of the given month; an invalid month falls back to 31 days.
    function automatic logic [7:0] max_day(input logic [7:0] month, input logic [7:0] year);
        logic [7:0] m;
        logic [7:0] y;
        logic [7:0] d;
        m = bcd_to_bin(month);
        y = bcd_to_bin(year);
        d = 8'h31;
        if (m >= 8'd1 && m <= 8'd12) d = MONTH_LEN[4'(m - 8'd1)];
        if (m == 8'd2 && (y % 8'd4) == 8'd0) d = 8'h29;
        return d;
    endfunction

endpackage

// File: rtl/rtc_bcd_step.sv
// Two-digit BCD increment (or decrement) between min_val and max_val with wrap flag.
module rtc_bcd_step #(
    parameter bit DOWN = 1'b0
) (
    input  logic [7:0] value,
    input  logic [7:0] min_val,
    input  logic [7:0] max_val,
    output logic [7:0] next,
    output logic       wrap
);

    logic bad_digit;

    assign bad_digit = (value[3:0] > 4'd9) || (value[7:4] > 4'd9);

    // Out-of-range digits or the end value wrap to the opposite limit.
    always_comb begin
        next = value;
        wrap = 1'b0;
        if (!DOWN) begin
            if (bad_digit || value >= max_val) begin
                next = min_val;
                wrap = 1'b1;
            end else if (value[3:0] == 4'd9) begin
                next = {value[7:4] + 4'd1, 4'd0};
            end else begin
                next = value + 8'd1;
            end
        end else begin
            if (bad_digit || value <= min_val) begin
                next = max_val;
                wrap = 1'b1;
            end else if (value[3:0] == 4'd0) begin
                next = {value[7:4] - 4'd1, 4'd9};
            end else begin
                next = value - 8'd1;
            end
        end
    end

endmodule

// File: rtl/rtc_bus_responder.sv
// RTC with BCD calendar, countdown timer and a strobed address/data bus slave.
module rtc_bus_responder
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_PER_SEC  = 100000000,
    parameter int unsigned TIMER_EN_BIT = 3
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       CS_n,
    input  logic       WR_n,
    input  logic       RD_n,
    input  logic       AD,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       alarma
);

    localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

    logic [PW-1:0] presc;
    logic          tick_pend;
    logic          cs_q, wr_q, ad_q;
    logic [7:0]    bus_q, addr_q;
    logic [7:0]    ctrl, sec, minute, hour, day, month, year;
    logic [7:0]    tmr_sec, tmr_min, tmr_hour;
    logic [7:0]    rd_data;

    logic tick_raw, tick_go, wr_rise, wr_data, oe_next;

    assign tick_raw = (presc == PW'(CLK_PER_SEC - 1));
    assign wr_rise  = !wr_q && WR_n && !cs_q;
    assign wr_data  = wr_rise && ad_q;
    assign tick_go  = (tick_raw || tick_pend) && !wr_data;
    assign oe_next  = !CS_n && !RD_n && (bus_oe || AD);

    // Calendar step logic
    logic [7:0] sec_nx, min_nx, hour_nx, day_nx, month_nx, year_nx;
    logic       sec_wrap, min_wrap, hour_wrap, day_wrap, month_wrap, year_wrap;
    logic       mode12, pm, day_carry;
    logic [7:0] hour12, hour_val, hour_min, hour_max, hour_next, day_max;

    assign mode12    = ctrl[CTRL_12H_BIT];
    assign pm        = hour[HOUR_PM_BIT];
    assign hour12    = {3'b000, hour[4:0]};
    assign hour_val  = mode12 ? hour12 : hour;
    assign hour_min  = mode12 ? 8'h01 : 8'h00;
    assign hour_max  = mode12 ? 8'h12 : 8'h23;
    assign hour_next = mode12 ? {2'b00, pm ^ (hour12 == 8'h11), hour_nx[4:0]} : hour_nx;
    assign day_carry = mode12 ? (hour12 == 8'h11 && pm) : hour_wrap;
    assign day_max   = max_day(month, year);

    rtc_bcd_step u_sec_step   (.value(sec),      .min_val(8'h00),    .max_val(8'h59),    .next(sec_nx),   .wrap(sec_wrap));
    rtc_bcd_step u_min_step   (.value(minute),   .min_val(8'h00),    .max_val(8'h59),    .next(min_nx),   .wrap(min_wrap));
    rtc_bcd_step u_hour_step  (.value(hour_val), .min_val(hour_min), .max_val(hour_max), .next(hour_nx),  .wrap(hour_wrap));
    rtc_bcd_step u_day_step   (.value(day),      .min_val(8'h01),    .max_val(day_max),  .next(day_nx),   .wrap(day_wrap));
    rtc_bcd_step u_month_step (.value(month),    .min_val(8'h01),    .max_val(8'h12),    .next(month_nx), .wrap(month_wrap));
    rtc_bcd_step u_year_step  (.value(year),     .min_val(8'h00),    .max_val(8'h99),    .next(year_nx),  .wrap(year_wrap));

    // Countdown timer step logic
    logic [7:0] tsec_nx, tmin_nx, thour_nx, tmr_min_d, tmr_hour_d;
    logic       tsec_wrap, tmin_wrap, thour_wrap, tmr_run, tmr_zero_next;
    logic       unused_wrap;

    rtc_bcd_step #(.DOWN(1'b1)) u_tsec_step  (.value(tmr_sec),  .min_val(8'h00), .max_val(8'h59), .next(tsec_nx),  .wrap(tsec_wrap));
    rtc_bcd_step #(.DOWN(1'b1)) u_tmin_step  (.value(tmr_min),  .min_val(8'h00), .max_val(8'h59), .next(tmin_nx),  .wrap(tmin_wrap));
    rtc_bcd_step #(.DOWN(1'b1)) u_thour_step (.value(tmr_hour), .min_val(8'h00), .max_val(8'h99), .next(thour_nx), .wrap(thour_wrap));

    assign tmr_min_d     = tsec_wrap ? tmin_nx : tmr_min;
    assign tmr_hour_d    = (tsec_wrap && tmin_wrap) ? thour_nx : tmr_hour;
    assign tmr_run       = ctrl[TIMER_EN_BIT] && ((tmr_sec | tmr_min | tmr_hour) != 8'h00);
    assign tmr_zero_next = (tsec_nx == 8'h00) && (tmr_min_d == 8'h00) && (tmr_hour_d == 8'h00);
    assign unused_wrap   = year_wrap ^ thour_wrap;

    // Register read mux; unmapped addresses read as zero.
    always_comb begin
        rd_data = 8'h00;
        case (addr_q)
            ADDR_CTRL:   rd_data = ctrl;
            ADDR_SEC:    rd_data = sec;
            ADDR_MIN:    rd_data = minute;
            ADDR_HOUR:   rd_data = hour;
            ADDR_DAY:    rd_data = day;
            ADDR_MONTH:  rd_data = month;
            ADDR_YEAR:   rd_data = year;
            ADDR_TSEC:   rd_data = tmr_sec;
            ADDR_TMIN:   rd_data = tmr_min;
            ADDR_THOUR:  rd_data = tmr_hour;
            ADDR_STATUS: rd_data[STATUS_ALARM_BIT] = alarma;
            default:     rd_data = 8'h00;
        endcase
    end

    // Bus strobe history, address latch and read data drive.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            ad_q    <= 1'b0;
            bus_q   <= 8'h00;
            addr_q  <= 8'h00;
            bus_oe  <= 1'b0;
            bus_out <= 8'h00;
        end else begin
            cs_q   <= CS_n;
            wr_q   <= WR_n;
            ad_q   <= AD;
            bus_q  <= bus_in;
            if (wr_rise && !ad_q) addr_q <= bus_q;
            bus_oe <= oe_next;
            if (oe_next && !bus_oe) bus_out <= rd_data;
        end
    end

    // One-second prescaler; a tick colliding with a host write waits one cycle.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            presc     <= '0;
            tick_pend <= 1'b0;
        end else begin
            presc     <= tick_raw ? '0 : presc + PW'(1);
            tick_pend <= (tick_raw || tick_pend) && wr_data;
        end
    end

    // Host writes take priority; otherwise a tick advances the calendar and timer.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            ctrl     <= 8'h00;
            sec      <= 8'h00;
            minute   <= 8'h00;
            hour     <= 8'h00;
            day      <= 8'h01;
            month    <= 8'h01;
            year     <= 8'h00;
            tmr_sec  <= 8'h00;
            tmr_min  <= 8'h00;
            tmr_hour <= 8'h00;
            alarma   <= 1'b0;
        end else if (wr_data) begin
            case (addr_q)
                ADDR_CTRL:   ctrl     <= bus_q;
                ADDR_SEC:    sec      <= bus_q;
                ADDR_MIN:    minute   <= bus_q;
                ADDR_HOUR:   hour     <= bus_q;
                ADDR_DAY:    day      <= bus_q;
                ADDR_MONTH:  month    <= bus_q;
                ADDR_YEAR:   year     <= bus_q;
                ADDR_TSEC:   tmr_sec  <= bus_q;
                ADDR_TMIN:   tmr_min  <= bus_q;
                ADDR_THOUR:  tmr_hour <= bus_q;
                ADDR_STATUS: if (bus_q[STATUS_ALARM_BIT]) alarma <= 1'b0;
                default: ;
            endcase
        end else if (tick_go) begin
            sec <= sec_nx;
            if (sec_wrap) begin
                minute <= min_nx;
                if (min_wrap) begin
                    hour <= hour_next;
                    if (day_carry) begin
                        day <= day_nx;
                        if (day_wrap) begin
                            month <= month_nx;
                            if (month_wrap) year <= year_nx;
                        end
                    end
                end
            end
            if (tmr_run) begin
                tmr_sec  <= tsec_nx;
                tmr_min  <= tmr_min_d;
                tmr_hour <= tmr_hour_d;
                if (tmr_zero_next) alarma <= 1'b1;
            end
        end
    end

endmodule
